// File: rtl/decode_stage_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, instruction
// field positions, control/pipeline-register types and decode helpers.
package decode_stage_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  typedef struct packed {
    logic          legal;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          alu_imm;
    logic [AW-1:0] rd;
  } ctrl_t;

  typedef struct packed {
    logic          valid;
    logic [31:0]   npc;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   imm;
    logic [AW-1:0] rd;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          alu_imm;
  } idex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Destination 0 means "no write", so reg_write follows from the chosen rd.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op,
                                        input logic [AW-1:0] rt,
                                        input logic [AW-1:0] rd);
    ctrl_t c;
    c       = '0;
    c.legal = 1'b1;
    case (op)
      OP_RTYPE: c.rd = rd;
      OP_ADDI: begin
        c.rd      = rt;
        c.alu_imm = 1'b1;
      end
      OP_LW: begin
        c.rd       = rt;
        c.mem_read = 1'b1;
        c.alu_imm  = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_imm   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_J: ;
      default: c.legal = 1'b0;
    endcase
    c.reg_write = (c.rd != '0);
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, write-back and ID/EX signal bundle around the decode stage.
// master drives fetch/write-back inputs; slave is the decode stage itself.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic [31:0]   ir_if;
  logic [31:0]   npc_if;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_data;
  logic          pc_update;
  logic [31:0]   pc_i;
  logic          id_valid;
  logic [31:0]   id_npc;
  logic [31:0]   id_a;
  logic [31:0]   id_b;
  logic [31:0]   id_imm;
  logic [AW-1:0] id_rd;
  logic [5:0]    id_op;
  logic [5:0]    id_funct;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_alu_imm;
  logic          id_illegal;

  modport master (
    output ir_if, npc_if, wb_we, wb_addr, wb_data,
    input  pc_update, pc_i, id_valid, id_npc, id_a, id_b, id_imm, id_rd,
           id_op, id_funct, id_reg_write, id_mem_read, id_mem_write,
           id_alu_imm, id_illegal
  );

  modport slave (
    input  ir_if, npc_if, wb_we, wb_addr, wb_data,
    output pc_update, pc_i, id_valid, id_npc, id_a, id_b, id_imm, id_rd,
           id_op, id_funct, id_reg_write, id_mem_read, id_mem_write,
           id_alu_imm, id_illegal
  );

endinterface

// File: rtl/decode_stage_regfile_2r1w.sv
// Register file: two async read ports, one sync write port, r0 reads zero,
// same-cycle write data bypassed to the readers, synchronous clear on rst.
module regfile_2r1w #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  // NOTE: clearing a memory on reset forces it into flops; this file is
  // small enough that the architectural "all registers zero" guarantee wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0)              ? '0    :
                   (we && waddr == raddr_a)     ? wdata : mem[raddr_a];
  assign rdata_b = (raddr_b == '0)              ? '0    :
                   (we && waddr == raddr_b)     ? wdata : mem[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register read with write-back bypass, immediate
// sign-extension, branch/jump resolution back to fetch, ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  logic [5:0]    op;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [31:0]   a;
  logic [31:0]   b;
  logic [31:0]   imm_ext;
  ctrl_t         ctrl;
  idex_t         idex_q;
  logic          illegal_q;
  logic          sq;
  logic          taken;
  logic [31:0]   target;

  assign op      = bus.ir_if[OP_LSB +: 6];
  assign rs      = bus.ir_if[RS_LSB +: AW];
  assign rt      = bus.ir_if[RT_LSB +: AW];
  assign rd      = bus.ir_if[RD_LSB +: AW];
  assign imm_ext = sext16(bus.ir_if[IMM_LSB +: 16]);
  assign ctrl    = decode_ctrl(op, rt, rd);

  regfile_2r1w #(.NREG(NREG), .AW(AW), .DW(32)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.wb_we),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (a),
    .rdata_b (b)
  );

  // NOTE: combinational logic uses blocking '=' with every output given a
  // default on the first lines, so no path leaves a latch behind.
  always_comb begin
    taken  = 1'b0;
    target = bus.npc_if + imm_ext;
    case (op)
      OP_BEQ: taken = (a == b);
      OP_BNE: taken = (a != b);
      OP_J: begin
        taken  = 1'b1;
        target = {bus.npc_if[31:26], bus.ir_if[25:0]};
      end
      default: ;
    endcase
    if (sq) taken = 1'b0;
  end

  assign bus.pc_update = taken;
  assign bus.pc_i      = taken ? target : bus.npc_if;

  // sq marks the slot behind a redirect (or the stale word after reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= '0;
      illegal_q <= 1'b0;
      sq        <= 1'b1;
    end else begin
      sq <= taken;
      if (sq || !ctrl.legal) begin
        idex_q <= '0;
      end else begin
        idex_q <= '{valid:     1'b1,
                    npc:       bus.npc_if,
                    a:         a,
                    b:         b,
                    imm:       imm_ext,
                    rd:        ctrl.rd,
                    op:        op,
                    funct:     bus.ir_if[FUNCT_LSB +: 6],
                    reg_write: ctrl.reg_write,
                    mem_read:  ctrl.mem_read,
                    mem_write: ctrl.mem_write,
                    alu_imm:   ctrl.alu_imm};
      end
      if (!sq && !ctrl.legal) illegal_q <= 1'b1;
    end
  end

  assign bus.id_valid     = idex_q.valid;
  assign bus.id_npc       = idex_q.npc;
  assign bus.id_a         = idex_q.a;
  assign bus.id_b         = idex_q.b;
  assign bus.id_imm       = idex_q.imm;
  assign bus.id_rd        = idex_q.rd;
  assign bus.id_op        = idex_q.op;
  assign bus.id_funct     = idex_q.funct;
  assign bus.id_reg_write = idex_q.reg_write;
  assign bus.id_mem_read  = idex_q.mem_read;
  assign bus.id_mem_write = idex_q.mem_write;
  assign bus.id_alu_imm   = idex_q.alu_imm;
  assign bus.id_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   started;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  bit          m_sq;
  bit          m_ill;
  bit          e_valid, e_rw, e_mr, e_mw, e_ai;
  logic [31:0] e_npc, e_a, e_b, e_imm;
  logic [4:0]  e_rd;
  logic [5:0]  e_op, e_funct;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_addr == idx) return bus.wb_data;
    return m_rf[idx];
  endfunction

  function automatic bit m_taken();
    logic [31:0] ra, rb;
    ra = m_read(bus.ir_if[25:21]);
    rb = m_read(bus.ir_if[20:16]);
    if (m_sq) return 1'b0;
    case (bus.ir_if[31:26])
      6'h02:   return 1'b1;
      6'h04:   return ra == rb;
      6'h05:   return ra != rb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_pc();
    if (!m_taken()) return bus.npc_if;
    if (bus.ir_if[31:26] == 6'h02) return {bus.npc_if[31:26], bus.ir_if[25:0]};
    return bus.npc_if + {{16{bus.ir_if[15]}}, bus.ir_if[15:0]};
  endfunction

  always @(posedge clk) begin
    logic [5:0] o;
    logic [4:0] dst;
    bit         legal;
    started <= 1'b1;
    o     = bus.ir_if[31:26];
    legal = (o == 6'h00 || o == 6'h08 || o == 6'h23 || o == 6'h2B ||
             o == 6'h04 || o == 6'h05 || o == 6'h02);
    if (rst) begin
      m_sq <= 1'b1; m_ill <= 1'b0;
      e_valid <= 0; e_rw <= 0; e_mr <= 0; e_mw <= 0; e_ai <= 0; e_rd <= '0;
      e_npc <= '0; e_a <= '0; e_b <= '0; e_imm <= '0; e_op <= '0; e_funct <= '0;
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
    end else begin
      m_sq <= m_taken();
      if (m_sq || !legal) begin
        e_valid <= 0; e_rw <= 0; e_mr <= 0; e_mw <= 0; e_ai <= 0; e_rd <= '0;
        if (!m_sq) m_ill <= 1'b1;
      end else begin
        dst = (o == 6'h00) ? bus.ir_if[15:11] :
              (o == 6'h08 || o == 6'h23) ? bus.ir_if[20:16] : 5'd0;
        e_valid <= 1'b1;
        e_npc   <= bus.npc_if;
        e_a     <= m_read(bus.ir_if[25:21]);
        e_b     <= m_read(bus.ir_if[20:16]);
        e_imm   <= {{16{bus.ir_if[15]}}, bus.ir_if[15:0]};
        e_op    <= o;
        e_funct <= bus.ir_if[5:0];
        e_rd    <= dst;
        e_rw    <= (dst != 5'd0);
        e_mr    <= (o == 6'h23);
        e_mw    <= (o == 6'h2B);
        e_ai    <= (o == 6'h08 || o == 6'h23 || o == 6'h2B);
      end
      if (bus.wb_we && bus.wb_addr != 5'd0) m_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_valid",   bus.id_valid,     e_valid);
      check("m_rw",      bus.id_reg_write, e_rw);
      check("m_mr",      bus.id_mem_read,  e_mr);
      check("m_mw",      bus.id_mem_write, e_mw);
      check("m_ai",      bus.id_alu_imm,   e_ai);
      check("m_rd",      bus.id_rd,        e_rd);
      check("m_illegal", bus.id_illegal,   m_ill);
      check("m_pc_upd",  bus.pc_update,    m_taken());
      check("m_pc_i",    bus.pc_i,         m_pc());
      if (e_valid) begin
        check("m_npc",   bus.id_npc,   e_npc);
        check("m_a",     bus.id_a,     e_a);
        check("m_b",     bus.id_b,     e_b);
        check("m_imm",   bus.id_imm,   e_imm);
        check("m_op",    bus.id_op,    e_op);
        check("m_funct", bus.id_funct, e_funct);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [31:0] ir, input logic [31:0] npc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.ir_if   = ir;
    bus.npc_if  = npc;
    bus.wb_we   = we;
    bus.wb_addr = wa;
    bus.wb_data = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.id_valid, 0);
    check({tag, "_npc"},   bus.id_npc,   0);
    check({tag, "_a"},     bus.id_a,     0);
    check({tag, "_b"},     bus.id_b,     0);
    check({tag, "_imm"},   bus.id_imm,   0);
    check({tag, "_rd"},    bus.id_rd,    0);
    check({tag, "_op"},    bus.id_op,    0);
    check({tag, "_funct"}, bus.id_funct, 0);
    check({tag, "_ctrl"},  {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_alu_imm}, 0);
    check({tag, "_ill"},   bus.id_illegal, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    started  = 1'b0;
    rst      = 1'b1;
    drive(NOP_WORD, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (3) tick();
    check_all_zero("rst");
    check("rst_pc_upd", bus.pc_update, 0);

    rst = 1'b0;
    drive(32'h1000_0005, 32'h20, 1'b0, 5'd0, 32'h0);     // BEQ r0,r0 in stale slot
    check("post_rst_pc_upd", bus.pc_update, 0);
    check("post_rst_pc_i",   bus.pc_i, 32'h20);
    check_all_zero("post_rst");
    tick();
    check("post_rst_bubble", bus.id_valid, 0);

    drive(NOP_WORD, 32'h1, 1'b1, 5'd1, 32'd5);           // r1 = 5
    tick();
    check("nop_valid", bus.id_valid, 1);
    check("nop_rw",    bus.id_reg_write, 0);

    drive(32'h2022_FFFD, 32'h2, 1'b0, 5'd0, 32'h0);      // ADDI r2,r1,-3
    tick();
    check("addi_valid", bus.id_valid, 1);
    check("addi_a",     bus.id_a, 32'd5);
    check("addi_imm",   bus.id_imm, 32'hFFFF_FFFD);
    check("addi_rd",    bus.id_rd, 2);
    check("addi_rw",    bus.id_reg_write, 1);
    check("addi_ai",    bus.id_alu_imm, 1);

    drive(32'h0061_3020, 32'h3, 1'b1, 5'd3, 32'h1234);   // R rs=3 bypassed
    tick();
    check("byp_a",  bus.id_a, 32'h1234);
    check("byp_b",  bus.id_b, 32'd5);
    check("byp_rd", bus.id_rd, 6);

    drive(32'h0003_3822, 32'h4, 1'b1, 5'd0, 32'hDEAD);   // write to r0, rs=0
    tick();
    check("r0_a", bus.id_a, 0);
    check("r0_b", bus.id_b, 32'h1234);

    drive(NOP_WORD, 32'h5, 1'b1, 5'd4, 32'd7); tick();
    drive(NOP_WORD, 32'h6, 1'b1, 5'd5, 32'd7); tick();

    drive(32'h1085_FFFC, 32'h10, 1'b0, 5'd0, 32'h0);     // BEQ r4,r5,-4 taken
    check("beq_pc_upd", bus.pc_update, 1);
    check("beq_pc_i",   bus.pc_i, 32'h0C);
    tick();
    check("beq_valid", bus.id_valid, 1);
    check("beq_rd",    bus.id_rd, 0);
    drive(32'h1085_FFFC, 32'h11, 1'b0, 5'd0, 32'h0);     // squashed slot
    check("sq_pc_upd", bus.pc_update, 0);
    check("sq_pc_i",   bus.pc_i, 32'h11);
    tick();
    check("sq_valid", bus.id_valid, 0);

    drive(32'h1485_0002, 32'h0D, 1'b0, 5'd0, 32'h0);     // BNE equal -> not taken
    check("bne_pc_upd", bus.pc_update, 0);
    check("bne_pc_i",   bus.pc_i, 32'h0D);
    tick();
    check("bne_valid", bus.id_valid, 1);

    drive(32'h0800_0123, 32'h40, 1'b0, 5'd0, 32'h0);     // J 0x123
    check("j_pc_upd", bus.pc_update, 1);
    check("j_pc_i",   bus.pc_i, 32'h123);
    tick();
    drive(NOP_WORD, 32'h124, 1'b0, 5'd0, 32'h0); tick();
    check("j_sq_valid", bus.id_valid, 0);

    drive(32'h0800_0123, 32'hFC00_0010, 1'b0, 5'd0, 32'h0);
    check("j_hi_pc_i", bus.pc_i, 32'hFC00_0123);
    tick();
    drive(NOP_WORD, 32'hFC00_0124, 1'b0, 5'd0, 32'h0); tick();

    drive(32'h8C28_0004, 32'h7, 1'b0, 5'd0, 32'h0);      // LW r8,4(r1)
    tick();
    check("lw_mr",  bus.id_mem_read, 1);
    check("lw_rd",  bus.id_rd, 8);
    check("lw_imm", bus.id_imm, 32'd4);

    drive(32'hAC25_FFFF, 32'h8, 1'b0, 5'd0, 32'h0);      // SW r5,-1(r1)
    tick();
    check("sw_mw",  bus.id_mem_write, 1);
    check("sw_rw",  bus.id_reg_write, 0);
    check("sw_b",   bus.id_b, 32'd7);
    check("sw_imm", bus.id_imm, 32'hFFFF_FFFF);

    drive(32'hFC00_0000, 32'h9, 1'b0, 5'd0, 32'h0);      // illegal op 0x3F
    tick();
    check("ill_valid", bus.id_valid, 0);
    check("ill_flag",  bus.id_illegal, 1);
    drive(NOP_WORD, 32'hA, 1'b0, 5'd0, 32'h0);
    repeat (2) tick();
    check("ill_sticky", bus.id_illegal, 1);
    check("ill_after_valid", bus.id_valid, 1);

    rst = 1'b1;                                          // mid-stream reset
    drive(NOP_WORD, 32'hB, 1'b1, 5'd9, 32'h99);
    tick();
    check_all_zero("mid_rst");
    rst = 1'b0;
    drive(32'h0029_0000, 32'h2E, 1'b0, 5'd0, 32'h0);
    tick();
    check("mid_sq_valid", bus.id_valid, 0);
    drive(32'h0029_0000, 32'h2F, 1'b0, 5'd0, 32'h0);
    tick();
    check("clr_valid", bus.id_valid, 1);
    check("clr_r1",    bus.id_a, 0);
    check("clr_r9",    bus.id_b, 0);

    drive(32'h1420_0008, 32'h30, 1'b1, 5'd1, 32'd3);     // BNE r1,r0 via bypass
    check("bne_byp_pc_upd", bus.pc_update, 1);
    check("bne_byp_pc_i",   bus.pc_i, 32'h38);
    tick();
    drive(NOP_WORD, 32'h38, 1'b0, 5'd0, 32'h0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode (ID) stage placed directly downstream of the fetch stage.
- Takes the registered instruction word ir_if and next-PC npc_if from fetch.
- Reads a 32x32 register file that has a write-back port, sign-extends immediates, and registers everything into the ID/EX pipeline register.
- Resolves BEQ/BNE/J in ID and drives pc_update/pc_i back to fetch, squashing the single wrong-path slot.

Parameters:
- NREG, 32, number of architectural registers; r0 reads as zero.
- AW, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ir_if  in  32  instruction word from fetch
- npc_if  in  32  word address of the instruction after ir_if
- wb_we  in  1  register write enable from write-back
- wb_addr  in  5  write-back destination
- wb_data  in  32  write-back data
- pc_update  out  1  combinational; redirect fetch this cycle
- pc_i  out  32  combinational; redirect target
- id_valid  out  1  ID/EX slot holds a real instruction
- id_npc  out  32  registered npc_if
- id_a  out  32  rs operand value
- id_b  out  32  rt operand value
- id_imm  out  32  sign-extended imm16
- id_rd  out  5  destination register (0 = none)
- id_op  out  6  opcode
- id_funct  out  6  funct field
- id_reg_write  out  1  instruction writes id_rd
- id_mem_read  out  1  load
- id_mem_write  out  1  store
- id_alu_imm  out  1  ALU B input is id_imm
- id_illegal  out  1  undefined opcode was seen (sticky until rst)

Behaviour:
- Fields: op=ir[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0]. Addresses are word addresses (npc = PC+1).
- Supported opcodes:
  - 00 R-type: dest rd, reg_write=1 unless rd=0.
  - 08 ADDI: dest rt, alu_imm=1.
  - 23 LW: dest rt, mem_read=1, alu_imm=1.
  - 2B SW: no dest, mem_write=1, alu_imm=1.
  - 04 BEQ, 05 BNE: no dest.
  - 02 J: no dest.
  - Word 0x00000000 is a NOP (valid, no side effects).
- Squash flag sq (internal register):
  - set by rst;
  - set on every edge where pc_update=1;
  - otherwise cleared each edge.
  - While sq=1, ir_if is treated as a bubble: no decode, pc_update=0.
- The rst-set sq squashes the first post-reset cycle, because fetch holds a stale word then.
- Branch resolution, combinational, only when sq=0:
  - BEQ taken if A==B; BNE taken if A!=B.
  - Branch target = npc_if + sext(imm), modulo 2^32.
  - J target = {npc_if[31:26], ir[25:0]}, always taken.
  - pc_update=1 and pc_i=target when taken; otherwise pc_update=0 and pc_i=npc_if.
- Register read:
  - A = rs==0 ? 0 : (wb_we && wb_addr==rs ? wb_data : rf[rs]); B likewise for rt.
  - The write-back bypass applies to both branch compare and id_a/id_b.
- Register write: at posedge, when wb_we and wb_addr!=0, rf[wb_addr] <= wb_data. Writes to r0 are ignored.
- ID/EX register, updated every posedge (1-cycle latency):
  - if sq=1 or the opcode is illegal: bubble — id_valid=0, all control bits 0, id_rd=0;
  - otherwise: id_valid=1 and all fields loaded.
  - An illegal opcode additionally sets id_illegal.
  - Branches and J enter ID/EX as valid with no control side effects.
- On rst (any cycle, including mid-operation):
  - all id_* outputs = 0, id_illegal = 0, sq = 1;
  - all rf entries cleared;
  - rst has priority over wb_we.
- A taken branch occupying the squashed slot has no effect. Two consecutive taken branches are impossible by construction.

Decomposition:
- Shared package/include holds the opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J), the field bit positions, and NOP_WORD.
- One sub-module, regfile_2r1w: 2 async read ports, 1 sync write port, r0 hardwired to zero, write-through bypass, synchronous clear on rst.
- Control decode and branch logic stay in decode_stage.

Test Plan:
- Reset: hold rst 3 cycles, release.
  - id_valid=0 and all outputs 0 during reset and for the first post-reset cycle.
  - pc_update=0 throughout.
- ALU decode: wb writes r1=5; then ir_if=ADDI r2,r1,-3 (0x2022FFFD).
  - Next edge: id_valid=1, id_a=5, id_imm=0xFFFFFFFD, id_rd=2, id_reg_write=1, id_alu_imm=1.
- Bypass: wb_we=1, wb_addr=3, wb_data=0x1234 in the same cycle as ir_if=R-type with rs=3.
  - id_a=0x1234.
  - A write to r0 leaves id_a=0 for rs=0.
- BEQ taken: r4=r5=7, npc_if=0x10, ir_if=BEQ r4,r5,-4.
  - Same cycle: pc_update=1, pc_i=0x0C.
  - Next slot squashed: id_valid=0, even if it holds a BEQ.
- BNE not taken with equal operands gives pc_update=0 and pc_i=npc_if. J with npc_if=0x40, target 0x123 gives pc_i=0x123.
- Illegal opcode 0x3F: bubble issued and id_illegal=1, held until rst. Asserting rst mid-stream clears rf (a read of r1 returns 0) and the ID/EX register.
